inst_fetch: RTL and testbench

- Reader/initiator side of the instruction memory interface.
- Holds the program counter and drives word addresses into the instruction memory. The memory has a synchronous 1-cycle read latency and its contents are loaded on the memory's own reset.
- Captures the returned words into a 2-entry skid buffer and presents them to decode with a valid/ready handshake. Supports stall (backpressure), fetch enable and branch redirect with squash of the in-flight read.

---
 rtl/inst_fetch_pkg.sv | 18 +
 rtl/inst_fetch_if.sv | 31 +++
 rtl/inst_fetch_skid_buf.sv | 69 ++++++
 rtl/inst_fetch.sv | 104 ++++++++++
 tb/tb_inst_fetch.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch slice.
// Holds the default widths, the reset PC, the NOP encoding handed to decode,
// and a helper for computing buffer-plus-in-flight occupancy.
package inst_fetch_pkg;

    localparam int unsigned IF_ADDR_W   = 16;
    localparam int unsigned IF_DATA_W   = 32;
    localparam int unsigned IF_RESET_PC = 0;

    // Encoding decode substitutes while instr_valid is low.
    localparam logic [31:0] NOP_INSTR = 32'h0;

    // Words held in the skid buffer plus the read currently in flight.
    function automatic logic [1:0] occupancy(input logic [1:0] count, input logic inflight);
        return count + {1'b0, inflight};
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Bus bundle between the fetch unit and its neighbours.
//   imem_addr/imem_write/imem_datain : fetch -> instruction memory
//   imem_dataout                     : instruction memory -> fetch (1-cycle latency)
//   instr/instr_pc/instr_valid       : fetch -> decode
//   instr_ready                      : decode -> fetch
// master = fetch side, slave = memory/decode side.
interface inst_fetch_if #(
    parameter int unsigned ADDR_W = inst_fetch_pkg::IF_ADDR_W,
    parameter int unsigned DATA_W = inst_fetch_pkg::IF_DATA_W
);
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_write;
    logic [DATA_W-1:0] imem_datain;
    logic [DATA_W-1:0] imem_dataout;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;

    modport master (
        output imem_addr, imem_write, imem_datain,
        output instr, instr_pc, instr_valid,
        input  imem_dataout, instr_ready
    );

    modport slave (
        input  imem_addr, imem_write, imem_datain,
        input  instr, instr_pc, instr_valid,
        output imem_dataout, instr_ready
    );
endinterface

// File: rtl/inst_fetch_skid_buf.sv
// fetch_skid_buf: 2-entry FIFO of {pc, word} between instruction memory and decode.
// Ports:
//   clk, reset           : clock, synchronous active-high reset (clears entries too)
//   flush                : empty the FIFO (branch redirect); wins over push/pop
//   push, push_pc/word   : write an entry at the tail
//   pop                  : drop the head entry (caller guarantees non-empty)
//   head_pc, head_word   : head entry contents
//   count                : number of valid entries, 0..2
module fetch_skid_buf
    import inst_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = IF_ADDR_W,
    parameter int unsigned DATA_W = IF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic [DATA_W-1:0] push_word,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_pc,
    output logic [DATA_W-1:0] head_word,
    output logic [1:0]        count
);

    logic [ADDR_W-1:0] pc_q   [2];
    logic [DATA_W-1:0] word_q [2];
    logic              head_ptr;
    logic              tail_ptr;
    logic [1:0]        count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 2; i++) begin
                pc_q[i]   <= '0;
                word_q[i] <= '0;
            end
            head_ptr <= 1'b0;
            tail_ptr <= 1'b0;
            count_q  <= '0;
        end else if (flush) begin
            head_ptr <= 1'b0;
            tail_ptr <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push) begin
                pc_q[tail_ptr]   <= push_pc;
                word_q[tail_ptr] <= push_word;
                tail_ptr         <= ~tail_ptr;
            end
            if (pop) begin
                head_ptr <= ~head_ptr;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        head_pc   = pc_q[head_ptr];
        head_word = word_q[head_ptr];
        count     = count_q;
    end

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: program counter and read initiator for the instruction memory.
// Issues one word address per cycle when there is room, captures the word that
// returns a cycle later into a 2-entry skid buffer, and hands it to decode.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   fetch_en            : allow new memory reads
//   redirect_valid/_pc  : branch target; flushes buffer and squashes in-flight read
//   bus (master)        : imem_addr/imem_write/imem_datain/imem_dataout to memory,
//                         instr/instr_pc/instr_valid/instr_ready to decode
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = IF_ADDR_W,
    parameter int unsigned       DATA_W   = IF_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IF_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    inst_fetch_if.master      bus
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] inflight_pc_q;
    logic              inflight_q;

    logic [ADDR_W-1:0] fetch_addr;
    logic [ADDR_W-1:0] head_pc;
    logic [DATA_W-1:0] head_word;
    logic [1:0]        count;
    logic [1:0]        occ;
    logic              valid;
    logic              pop;
    logic              push;
    logic              issue;

    always_comb begin
        fetch_addr = redirect_valid ? redirect_pc : pc_q;
        if (reset) begin
            fetch_addr = RESET_PC;
        end

        valid = (count != 2'd0);
        // A redirect takes the cycle: the head is not popped and the returning
        // word belongs to the wrong path.
        pop   = valid & bus.instr_ready & ~redirect_valid;
        push  = inflight_q & ~redirect_valid;
        occ   = occupancy(count, inflight_q);

        // Issue only when the word can be guaranteed a buffer slot on arrival.
        if (redirect_valid) begin
            issue = fetch_en;
        end else begin
            issue = fetch_en & ((occ <= 2'd1) | ((occ == 2'd2) & pop));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else if (issue) begin
            pc_q          <= fetch_addr + ADDR_W'(1);
            inflight_q    <= 1'b1;
            inflight_pc_q <= fetch_addr;
        end else begin
            inflight_q <= 1'b0;
            if (redirect_valid) begin
                pc_q <= redirect_pc;
            end
        end
    end

    fetch_skid_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_pc   (inflight_pc_q),
        .push_word (bus.imem_dataout),
        .pop       (pop),
        .head_pc   (head_pc),
        .head_word (head_word),
        .count     (count)
    );

    always_comb begin
        bus.imem_addr   = fetch_addr;
        bus.imem_write  = 1'b0;
        bus.imem_datain = '0;
        bus.instr       = head_word;
        bus.instr_pc    = head_pc;
        bus.instr_valid = valid;
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (reset) occ <= 2'd2);

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk;
    logic        reset;
    logic        fetch_en;
    logic        redirect_valid;
    logic [15:0] redirect_pc;

    inst_fetch_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    inst_fetch #(
        .ADDR_W   (16),
        .DATA_W   (32),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: synchronous read, one cycle latency.
    logic [31:0] mem [65536];
    always @(posedge clk) bus.imem_dataout <= mem[bus.imem_addr];

    int unsigned n_cmp;
    int unsigned n_bad;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: queue of buffered PCs in delivery order plus the one
    // outstanding read, advanced with the issue/capture/redirect rules.
    logic [15:0] m_q[$];
    logic        m_pend;
    logic [15:0] m_pend_pc;
    logic [15:0] m_pc;
    bit          m_known;
    bit          m_after_reset;

    logic        obs_valid;
    logic [15:0] obs_pc;
    logic [31:0] obs_instr;
    logic [15:0] obs_addr;

    task automatic step(input logic fen, input logic rdy, input logic rv,
                        input logic [15:0] rpc, input logic rst);
        logic [15:0] exp_addr;
        logic        pop;
        logic        issue;
        int          occ;
        @(negedge clk);
        reset          = rst;
        fetch_en       = fen;
        bus.instr_ready = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        obs_valid = bus.instr_valid;
        obs_pc    = bus.instr_pc;
        obs_instr = bus.instr;
        obs_addr  = bus.imem_addr;

        exp_addr = rst ? RESET_PC : (rv ? rpc : m_pc);
        check_val("imem_addr", 32'(obs_addr), 32'(exp_addr));
        check_val("imem_write", 32'(bus.imem_write), 32'd0);
        check_val("imem_datain", bus.imem_datain, 32'd0);
        if (m_known) begin
            check_val("instr_valid", 32'(obs_valid), 32'(m_q.size() > 0));
            if (m_q.size() > 0) begin
                check_val("instr_pc", 32'(obs_pc), 32'(m_q[0]));
                check_val("instr", obs_instr, mem[m_q[0]]);
            end
            if (m_after_reset) begin
                check_val("reset_instr_pc", 32'(obs_pc), 32'd0);
                check_val("reset_instr", obs_instr, 32'd0);
            end
        end

        // Advance the model across the coming clock edge.
        m_after_reset = 1'b0;
        if (rst) begin
            m_q.delete();
            m_pend        = 1'b0;
            m_pc          = RESET_PC;
            m_known       = 1'b1;
            m_after_reset = 1'b1;
        end else begin
            pop   = (m_q.size() > 0) && rdy && !rv;
            occ   = m_q.size() + int'(m_pend);
            issue = rv ? fen : (fen && (occ <= 1 || (occ == 2 && pop)));
            if (rv) begin
                m_q.delete();
            end else begin
                if (pop) void'(m_q.pop_front());
                if (m_pend) m_q.push_back(m_pend_pc);
            end
            if (issue) begin
                m_pend    = 1'b1;
                m_pend_pc = exp_addr;
                m_pc      = exp_addr + 16'd1;
            end else begin
                m_pend = 1'b0;
                if (rv) m_pc = rpc;
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        m_known = 1'b0;
        m_after_reset = 1'b0;
        m_pend = 1'b0;
        m_pend_pc = '0;
        m_pc = RESET_PC;
        reset = 1'b1;
        fetch_en = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        bus.instr_ready = 1'b0;

        for (int i = 0; i < 65536; i++) mem[i] = 32'(i) * 32'h9E3779B1 + 32'h1234_5678;
        mem[0] = 32'h08421000;
        mem[1] = 32'h82140000;
        mem[5] = 32'h2FFC0014;

        // Straight-line fetch after a 3-cycle reset.
        repeat (3) step(1'b1, 1'b1, 1'b0, 16'h0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
        check_val("first_addr", 32'(obs_addr), 32'h0);
        step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
        check_val("first_valid_lat", 32'(obs_valid), 32'h0);
        step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
        check_val("pc0_valid", 32'(obs_valid), 32'h1);
        check_val("pc0_instr", obs_instr, 32'h08421000);

        // Stall from the cycle pc 1 is at the head, then release.
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        check_val("pc1_instr", obs_instr, 32'h82140000);
        check_val("pc1_pc", 32'(obs_pc), 32'h1);
        repeat (4) step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        repeat (4) step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);

        // Redirect to 5 mid-stream.
        step(1'b1, 1'b1, 1'b1, 16'd5, 1'b0);
        check_val("redir_addr", 32'(obs_addr), 32'd5);
        step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
        check_val("redir_pc5", 32'(obs_pc), 32'd5);
        check_val("redir_instr5", obs_instr, 32'h2FFC0014);
        step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
        check_val("redir_pc6", 32'(obs_pc), 32'd6);

        // Redirect with a full buffer and decode stalled.
        repeat (4) step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 16'h0100, 1'b0);
        step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
        check_val("flush_empty", 32'(obs_valid), 32'h0);
        step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
        check_val("flush_target", 32'(obs_pc), 32'h0100);

        // Address wrap.
        step(1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b0);
        step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
        check_val("wrap_addr", 32'(obs_addr), 32'h0);
        step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
        check_val("wrap_pc_ffff", 32'(obs_pc), 32'hFFFF);
        step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
        check_val("wrap_pc_0", 32'(obs_pc), 32'h0);

        // fetch_en low for 4 cycles, then resume.
        repeat (4) step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
        check_val("fen_drained", 32'(obs_valid), 32'h0);
        repeat (4) step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);

        // Reset in the middle of a stall.
        repeat (3) step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
        check_val("rst_mid_valid", 32'(obs_valid), 32'h0);
        check_val("rst_mid_addr", 32'(obs_addr), 32'h0);
        repeat (4) step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3)) : 16'($urandom);
            step($urandom_range(0, 7) != 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0,
                 rpc,
                 $urandom_range(0, 149) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
